tty_tx_ctrl: RTL

Memory-mapped terminal transmit controller on the shared CPU bus. Replaces the write-only simulation terminal with a synthesizable path: CPU writes bytes into a TX FIFO, a bit-timing state machine serializes them as 8N1 on a single output line, and status and control registers expose FIFO state plus a drain-complete interrupt. Its enable comes from the top-level address decode, like every other bus slave.

---
 rtl/tty_tx_ctrl_if.sv | 12 +
 rtl/tty_tx_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tty_tx_ctrl_if.sv
// CPU-side register bus for the terminal transmit controller.
// The tri-stated read data stays a plain port on the slave.
interface tty_tx_ctrl_if;
  logic [1:0]  addr;
  logic [31:0] data;
  logic        rd;
  logic        wr;
  logic        en;

  modport master (output addr, data, rd, wr, en);
  modport slave  (input  addr, data, rd, wr, en);
endinterface

// File: rtl/tty_tx_ctrl.sv
// Memory-mapped 8N1 terminal transmitter: bus writes fill a TX FIFO that a
// bit-timing FSM drains onto the serial line, with status and a drain interrupt.
module tty_tx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 434
) (
  input  logic         clk,
  input  logic         rst,
  tty_tx_ctrl_if.slave bus,
  output logic [31:0]  out,
  output logic         tx,
  output logic         irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          ien;

  logic          full;
  logic          empty;
  logic          busy;
  logic          tick_end;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          stat_wr;
  logic          ctrl_wr;
  logic [31:0]   rdata;
  logic          unused_data;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign busy     = (state != S_IDLE);
  assign tick_end = (tick == TICK_LAST);
  assign push_req = bus.wr && bus.en && (bus.addr == 2'd0);
  assign stat_wr  = bus.wr && bus.en && (bus.addr == 2'd1);
  assign ctrl_wr  = bus.wr && bus.en && (bus.addr == 2'd2);

  // The head leaves the FIFO when an idle FSM sees data or a stop bit ends with more queued.
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && tick_end));
  assign push_ok = push_req && (!full || pop);

  // Upper write-data bits carry nothing for this slave.
  assign unused_data = ^bus.data[31:8];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= bus.data[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ien      <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok)      overflow <= 1'b1;
      else if (stat_wr && bus.data[3]) overflow <= 1'b0;
      if (ctrl_wr) ien <= bus.data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                           shift <= mem[rptr];
    else if ((state == S_DATA) && tick_end) shift <= {1'b0, shift[7:1]};
  end

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tick    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      irq     <= 1'b0;
    end else begin
      tx  <= 1'b1;
      irq <= ien && empty && !busy;
      case (state)
        S_IDLE: begin
          tick    <= '0;
          bit_idx <= '0;
          if (!empty) state <= S_START;
        end
        S_START: begin
          tx <= 1'b0;
          if (tick_end) begin
            tick  <= '0;
            state <= S_DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_DATA: begin
          tx <= shift[0];
          if (tick_end) begin
            tick    <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_end) begin
            tick  <= '0;
            state <= empty ? S_IDLE : S_START;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      2'd1:    rdata = {16'd0, 8'(count), 4'd0, overflow, busy, empty, full};
      2'd2:    rdata = {31'd0, ien};
      default: rdata = '0;
    endcase
  end

  assign out = (bus.rd && bus.en) ? rdata : {32{1'bz}};
endmodule
